// File: rtl/clk_div_multi_pkg.sv
// rtl/clk_div_multi_pkg.sv - shared constants, rate helpers and channel op type for clk_div_multi
//
// Purpose : Single home for the divider defaults and the named rate constants
//           used by the blink, debounce and lock-timeout consumers.
// Contents: CNT_W_DEF / DEFAULT_DIV_DEF   parameter defaults for the divider
//           BLINK_1HZ / DEBOUNCE_10MS     terminal counts at CLK_IN_HZ
//           div_for_period()              cycles-per-wrap -> terminal count
//           chan_op_e                     per-channel action chosen each cycle
package clk_div_multi_pkg;

    localparam int unsigned CLK_IN_HZ = 25_000_000;

    localparam int unsigned CNT_W_DEF       = 25;
    localparam int unsigned DEFAULT_DIV_DEF = 12_499_999;

    // A channel wraps every D+1 cycles, so the terminal count for a wrap
    // period of N cycles is N-1. A zero-length request clamps to D=0.
    function automatic int unsigned div_for_period(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

    // div_clk toggles on each wrap, so a 1 Hz blink needs a wrap every 0.5 s.
    localparam int unsigned BLINK_1HZ     = div_for_period(CLK_IN_HZ / 2);
    localparam int unsigned DEBOUNCE_10MS = div_for_period(CLK_IN_HZ / 100);

    // What a channel does on the coming edge. Loads are orthogonal to this:
    // div_reg capture and the counter zeroing are applied on top of the op.
    typedef enum logic [1:0] {
        CH_HOLD  = 2'd0,   // en low: counter and div_clk frozen, no tick
        CH_COUNT = 2'd1,   // en high, not at terminal count
        CH_WRAP  = 2'd2,   // en high, at terminal count: tick and toggle
        CH_CLEAR = 2'd3    // sync_clr: restart in phase, wins over everything
    } chan_op_e;

endpackage

// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - control/status bundle between a divider client and clk_div_multi
//
// Purpose : Groups the per-channel controls and the tick/div_clk outputs.
// Signals : en        [NUM_CH]        per-channel count enable
//           div_load  [NUM_CH]        per-channel terminal-count load strobe
//           div_val   [NUM_CH*CNT_W]  terminal counts, channel i at [i*CNT_W +: CNT_W]
//           sync_clr                  restart all channels in phase
//           tick      [NUM_CH]        one-cycle strobe per wrap
//           div_clk   [NUM_CH]        50% clock toggled per wrap
// Modports: master (client side), slave (divider side)
interface clk_div_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 25
);

    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH*CNT_W-1:0] div_val;
    logic                    sync_clr;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       div_clk;

    modport master (
        output en,
        output div_load,
        output div_val,
        output sync_clr,
        input  tick,
        input  div_clk
    );

    modport slave (
        input  en,
        input  div_load,
        input  div_val,
        input  sync_clr,
        output tick,
        output div_clk
    );

endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one programmable divider channel (terminal count, counter, tick, div_clk)
//
// Purpose : Counts enabled cycles up to a runtime-loadable terminal count D,
//           emitting a one-cycle tick and toggling div_clk on every wrap.
// Ports   : clk_in    in   clock, posedge
//           rst       in   asynchronous active-low reset
//           en        in   count enable
//           div_load  in   capture div_val as the new terminal count
//           div_val   in   terminal count [CNT_W]
//           sync_clr  in   restart: counter, tick and div_clk to 0
//           tick      out  registered one-cycle wrap strobe
//           div_clk   out  registered clock, period 2*(D+1)
module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             sync_clr,
    output logic             tick,
    output logic             div_clk
);

    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] cnt;
    logic             at_term;
    chan_op_e         op;

    // Equality only: cnt is zeroed on every load, so it can never sit above D.
    assign at_term = (cnt == div_reg);

    always_comb begin
        op = CH_HOLD;
        if (sync_clr) begin
            op = CH_CLEAR;
        end else if (en && at_term) begin
            op = CH_WRAP;
        end else if (en) begin
            op = CH_COUNT;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_reg <= CNT_W'(DEFAULT_DIV);
            cnt     <= '0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
        end else begin
            // Capture happens regardless of en and even alongside sync_clr.
            if (div_load) begin
                div_reg <= div_val;
            end

            unique case (op)
                CH_CLEAR: begin
                    cnt     <= '0;
                    tick    <= 1'b0;
                    div_clk <= 1'b0;
                end
                // A wrap coincident with a load still completes against the
                // old D; the counter lands on 0 either way.
                CH_WRAP: begin
                    cnt     <= '0;
                    tick    <= 1'b1;
                    div_clk <= ~div_clk;
                end
                CH_COUNT: begin
                    cnt  <= div_load ? '0 : cnt + CNT_W'(1);
                    tick <= 1'b0;
                end
                default: begin
                    if (div_load) begin
                        cnt <= '0;
                    end
                    tick <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH-channel programmable clock divider / tick generator
//
// Purpose : Supplies independent tick strobes and 50% divided clocks (blink,
//           debounce, lock timeout) from the single clk_in.
// Params  : NUM_CH       number of channels
//           CNT_W        counter / terminal-count width
//           DEFAULT_DIV  terminal count loaded at reset on every channel
// Ports   : clk_in   in   sole clock, posedge
//           rst      in   asynchronous active-low reset
//           bus      slave modport of clk_div_multi_if
//                    (en, div_load, div_val, sync_clr in; tick, div_clk out)
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    clk_div_multi_if.slave   bus
);

    logic [NUM_CH-1:0] tick_w;
    logic [NUM_CH-1:0] div_clk_w;

    // Channels share nothing but the clock, reset and sync_clr.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (bus.en[i]),
            .div_load (bus.div_load[i]),
            .div_val  (bus.div_val[i*CNT_W +: CNT_W]),
            .sync_clr (bus.sync_clr),
            .tick     (tick_w[i]),
            .div_clk  (div_clk_w[i])
        );
    end

    assign bus.tick    = tick_w;
    assign bus.div_clk = div_clk_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi
module tb_clk_div_multi;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DDEF = 3;

    logic clk_in;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Reference: each channel is described by how many enabled edges remain
    // until its next wrap, and by how many wraps since the last restart.
    int d     [NCH];
    int rem   [NCH];
    int wraps [NCH];
    logic [NCH-1:0] exp_tick;

    clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDEF)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [NCH-1:0] exp_div_clk();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = wraps[c][0];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            d[c]     = DDEF;
            rem[c]   = DDEF + 1;
            wraps[c] = 0;
        end
        exp_tick = '0;
    endtask

    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
        end
    endtask

    // One clk_in edge: advance the reference with the inputs held across
    // the edge, then compare both output vectors just after the edge.
    task automatic step();
        @(posedge clk_in);
        for (int c = 0; c < NCH; c++) begin
            int  newd;
            bit  w;
            newd = bus.div_load[c] ? int'(bus.div_val[c*CW +: CW]) : d[c];
            w    = 1'b0;
            if (bus.sync_clr) begin
                wraps[c] = 0;
                rem[c]   = newd + 1;
            end else begin
                if (bus.en[c]) begin
                    rem[c]--;
                    if (rem[c] == 0) w = 1'b1;
                end
                if (w) wraps[c]++;
                if (bus.div_load[c] || w) rem[c] = newd + 1;
            end
            exp_tick[c] = w;
            d[c]        = newd;
        end
        #1;
        chk("tick", bus.tick, exp_tick);
        chk("div_clk", bus.div_clk, exp_div_clk());
    endtask

    task automatic set_val(input int c, input int v);
        bus.div_val[c*CW +: CW] = CW'(v);
    endtask

    initial begin
        int n;
        bit hit;
        int first [NCH];

        rst          = 1'b0;
        bus.en       = '0;
        bus.div_load = '0;
        bus.div_val  = '0;
        bus.sync_clr = 1'b0;
        model_reset();

        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_tick", bus.tick, '0);
        chk("reset_div_clk", bus.div_clk, '0);

        // 1: free run at default D=3
        #2;
        rst    = 1'b1;
        bus.en = '1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t1_tick", bus.tick, (k % 4 == 0) ? 4'hF : 4'h0);
            chk("t1_div_clk", bus.div_clk, ((k / 4) % 2 == 1) ? 4'hF : 4'h0);
        end

        // 2: ch1 to D=0, others stay at 3
        bus.div_load = 4'b0010;
        set_val(1, 0);
        step();
        bus.div_load = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_ch1_tick", {3'b0, bus.tick[1]}, 4'b0001);
        end

        // 3: ch2 load D=9 on the wrap edge
        n = 0;
        while (rem[2] != 1 && n < 20) begin
            step();
            n++;
        end
        chk("t3_reach_term", {3'b0, rem[2] == 1}, 4'b0001);
        bus.div_load = 4'b0100;
        set_val(2, 9);
        step();
        bus.div_load = '0;
        chk("t3_wrap_on_load", {3'b0, bus.tick[2]}, 4'b0001);
        n = 0;
        hit = 1'b0;
        while (!hit && n < 30) begin
            step();
            n++;
            hit = bus.tick[2];
        end
        chk("t3_next_tick_gap", 4'(n), 4'(10));

        // 4: pause ch0 at cnt==2 (two edges before its wrap)
        n = 0;
        while (rem[0] != 2 && n < 20) begin
            step();
            n++;
        end
        chk("t4_reach_cnt2", {3'b0, rem[0] == 2}, 4'b0001);
        bus.en[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_paused_tick", {3'b0, bus.tick[0]}, 4'b0000);
        end
        bus.en[0] = 1'b1;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            step();
            n++;
            hit = bus.tick[0];
        end
        chk("t4_resume_gap", 4'(n), 4'(2));

        // 5: sync_clr with channels at D=3 and D=5
        bus.div_load = 4'hF;
        set_val(0, 3);
        set_val(1, 3);
        set_val(2, 5);
        set_val(3, 5);
        step();
        bus.div_load = '0;
        step();
        step();
        bus.sync_clr = 1'b1;
        step();
        bus.sync_clr = 1'b0;
        chk("t5_clr_div_clk", bus.div_clk, 4'h0);
        for (int c = 0; c < NCH; c++) first[c] = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            for (int c = 0; c < NCH; c++)
                if (bus.tick[c] && first[c] == 0) first[c] = k;
        end
        chk("t5_first_tick_ch0", 4'(first[0]), 4'(4));
        chk("t5_first_tick_ch3", 4'(first[3]), 4'(6));

        // Randomised traffic against the reference
        for (int k = 0; k < 400; k++) begin
            bus.en       = 4'($urandom_range(0, 15) | ($urandom_range(0, 3) == 0 ? 0 : 4'hF));
            bus.div_load = '0;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) == 0) bus.div_load[c] = 1'b1;
                set_val(c, $urandom_range(0, 7));
            end
            bus.sync_clr = ($urandom_range(0, 49) == 0);
            step();
        end
        bus.en       = '1;
        bus.div_load = '0;
        bus.sync_clr = 1'b0;
        step();
        step();

        // 6: asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t6_async_tick", bus.tick, '0);
        chk("t6_async_div_clk", bus.div_clk, '0);
        @(posedge clk_in);
        #2;
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t6_default_d", bus.tick, (k % 4 == 0) ? 4'hF : 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
